// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO stream reader.
// The state encoding and the depth of the output buffer are defined here.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        DONE
    } rd_state_e;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

    localparam logic [OCC_W-1:0] OCC_EMPTY = '0;
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(BUF_DEPTH);

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry register buffer that absorbs the FIFO read latency.
// slot0 is always the head, so dout only changes when a word leaves.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only legal when a pop frees a slot in the same cycle.
    assign do_pop  = pop && (occ != OCC_EMPTY);
    assign do_push = push && ((occ != OCC_FULL) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ   <= OCC_EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ == OCC_EMPTY) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    occ <= occ + OCC_ONE;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - OCC_ONE;
                end
                2'b11: begin
                    if (occ == OCC_ONE) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout  = slot0;
    assign valid = (occ != OCC_EMPTY);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a fixed-length burst from the synchronous FIFO read port onto a
// valid/ready stream, tagging the final word with m_last.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int LEN_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      rd_count,
    output logic                  err,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    rd_state_e        state;
    rd_state_e        next_state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] issued;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic             pop;
    logic             accept;
    logic [2:0]       pending;

    assign accept = (state == IDLE) && start;
    assign pop    = m_valid && m_ready;

    // Words already buffered plus the one in flight, less the one leaving now.
    assign pending = {{(3-OCC_W){1'b0}}, occ} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        next_state = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (burst_len != '0) ? READ : DONE;
                end
            end
            READ: begin
                fifo_rd_en = !fifo_empty && (issued < len) && (pending < 3'd2);
                if (fifo_rd_en && ((issued + LEN_W'(1)) == len)) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (!inflight && (occ == OCC_EMPTY)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len      <= '0;
            issued   <= '0;
            rd_count <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (accept) begin
                len      <= burst_len;
                issued   <= '0;
                rd_count <= '0;
            end else begin
                if (fifo_rd_en) begin
                    issued <= issued + LEN_W'(1);
                end
                if (pop) begin
                    rd_count <= rd_count + LEN_W'(1);
                end
            end
        end
    end

    // A fresh underflow wins over the clear from a start in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (fifo_underflow) begin
            err <= 1'b1;
        end else if (accept) begin
            err <= 1'b0;
        end
    end

    rd_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_data_out),
        .dout  (m_data),
        .valid (m_valid),
        .occ   (occ)
    );

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign m_last = m_valid && (rd_count == (len - LEN_W'(1)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-based FIFO model feeds the
// read port and every delivered stream word is popped from an expected queue.
module tb_fifo_stream_reader;

    localparam int W     = 16;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] rd_count;
    logic             err;
    logic             fifo_rd_en;
    logic [W-1:0]     fifo_data_out = '0;
    logic             fifo_empty;
    logic             fifo_underflow;
    logic [W-1:0]     m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] fifo_q[$];
    int           pushed_total = 0;
    int           popped_total = 0;
    int           rd_pulses = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .burst_len      (burst_len),
        .busy           (busy),
        .done           (done),
        .rd_count       (rd_count),
        .err            (err),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last)
    );

    assign fifo_empty = (pushed_total == popped_total);

    // FIFO model: one-cycle read latency, flags any read of an empty FIFO.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulses <= rd_pulses + 1;
            if (fifo_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL read_of_empty_fifo got rd_en=1 want rd_en=0");
            end else begin
                fifo_data_out <= fifo_q.pop_front();
                popped_total  <= popped_total + 1;
            end
        end
    end

    // Stream monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL stream_extra_word got %h want no word", m_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_data, m_last} !== {mon_e.data, mon_e.last}) begin
                    errors++;
                    $display("[TB] FAIL stream_word got data=%h last=%b want data=%h last=%b",
                             m_data, m_last, mon_e.data, mon_e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        fifo_q.push_back(d);
        pushed_total++;
        exp_q.push_back(e);
    endtask

    task automatic fire_start(input logic [LEN_W-1:0] n);
        start     = 1'b1;
        burst_len = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic [LEN_W-1:0] cnt);
        seen = 1'b0;
        cnt  = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                cnt  = rd_count;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        burst_len      = '0;
        m_ready        = 1'b0;
        fifo_underflow = 1'b0;
        #12;
        checks++;
        if ({busy, done, err, m_valid, m_last, fifo_rd_en} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 000000",
                     {busy, done, err, m_valid, m_last, fifo_rd_en});
        end
        checks++;
        if (rd_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rd_count got %0d want 0", rd_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_burst();
        int rd_first = -1, rd_last = -1, rd_n = 0;
        int pop_first = -1, pop_last = -1, pop_n = 0;
        int done_k = -1, done_n = 0, last_k = -1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(W'(16'hA1 + i), i == 3);
        fire_start(4'd4);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                if (rd_first < 0) rd_first = k;
                rd_last = k;
                rd_n++;
            end
            if (m_valid && m_ready) begin
                if (pop_first < 0) pop_first = k;
                pop_last = k;
                pop_n++;
            end
            if (m_valid && m_last) last_k = k;
            if (done) begin
                done_k = k;
                done_n++;
            end
        end
        checks++;
        if (rd_n != 4 || rd_first != 0 || rd_last != 3) begin
            errors++;
            $display("[TB] FAIL basic_rd_en got n=%0d first=%0d last=%0d want n=4 first=0 last=3",
                     rd_n, rd_first, rd_last);
        end
        checks++;
        if (pop_first != 2) begin
            errors++;
            $display("[TB] FAIL basic_first_valid got cycle %0d want 2", pop_first);
        end
        checks++;
        if (pop_n != 4 || pop_last != pop_first + 3) begin
            errors++;
            $display("[TB] FAIL basic_words got n=%0d span=%0d want n=4 span=3",
                     pop_n, pop_last - pop_first);
        end
        checks++;
        if (last_k != pop_last) begin
            errors++;
            $display("[TB] FAIL basic_last_cycle got %0d want %0d", last_k, pop_last);
        end
        checks++;
        if (done_n != 1 || done_k <= pop_last) begin
            errors++;
            $display("[TB] FAIL basic_done got pulses=%0d cycle=%0d want pulses=1 after %0d",
                     done_n, done_k, pop_last);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL basic_leftover got %0d words want 0", exp_q.size());
        end
        tick();
    endtask

    task automatic test_backpressure();
        int p0;
        bit seen;
        logic [LEN_W-1:0] cnt;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(W'(16'hA1 + i), i == 3);
        p0 = rd_pulses;
        fire_start(4'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                checks++;
                if ({m_valid, m_data} !== {1'b1, 16'h00A1}) begin
                    errors++;
                    $display("[TB] FAIL stall_hold got valid=%b data=%h want valid=1 data=00a1",
                             m_valid, m_data);
                end
            end
        end
        checks++;
        if (rd_pulses - p0 != 2) begin
            errors++;
            $display("[TB] FAIL stall_reads got %0d want 2", rd_pulses - p0);
        end
        tick();
        m_ready = 1'b1;
        wait_done(30, seen, cnt);
        checks++;
        if (!seen || cnt !== 4'd4 || rd_pulses - p0 != 4) begin
            errors++;
            $display("[TB] FAIL stall_complete got done=%b count=%0d reads=%0d want done=1 count=4 reads=4",
                     seen, cnt, rd_pulses - p0);
        end
    endtask

    task automatic test_fifo_starved();
        int p0;
        bit seen;
        logic [LEN_W-1:0] cnt;
        m_ready = 1'b1;
        push_word(16'h00C1, 1'b0);
        p0 = rd_pulses;
        fire_start(4'd3);
        for (int k = 0; k < 6; k++) @(negedge clk);
        checks++;
        if (rd_pulses - p0 != 1 || busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL starve_wait got reads=%0d busy=%b err=%b want reads=1 busy=1 err=0",
                     rd_pulses - p0, busy, err);
        end
        tick();
        push_word(16'h00C2, 1'b0);
        push_word(16'h00C3, 1'b1);
        wait_done(30, seen, cnt);
        checks++;
        if (!seen || cnt !== 4'd3 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL starve_complete got done=%b count=%0d err=%b want done=1 count=3 err=0",
                     seen, cnt, err);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL starve_leftover got %0d words want 0", exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        int p0;
        p0 = rd_pulses;
        fire_start(4'd0);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL zero_len_done got busy=%b done=%b want busy=1 done=1", busy, done);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00 || rd_count !== '0 || rd_pulses != p0) begin
            errors++;
            $display("[TB] FAIL zero_len_idle got busy=%b done=%b count=%0d reads=%0d want 0 0 0 0",
                     busy, done, rd_count, rd_pulses - p0);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(W'(16'hD1 + i), i == 3);
        fire_start(4'd4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, m_valid, m_last, fifo_rd_en} !== 6'b0 || rd_count !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got flags=%b count=%0d want 000000 0",
                     {busy, done, err, m_valid, m_last, fifo_rd_en}, rd_count);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        pushed_total = popped_total;
        tick();
        @(negedge clk);
        checks++;
        if ({m_valid, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_late_data got valid=%b busy=%b want 0 0", m_valid, busy);
        end
        tick();
    endtask

    task automatic test_underflow();
        bit seen;
        logic [LEN_W-1:0] cnt;
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_set got %b want 1", err);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_sticky got %b want 1", err);
        end
        tick();
        m_ready = 1'b1;
        push_word(16'h00E1, 1'b1);
        fire_start(4'd1);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow_clear got %b want 0", err);
        end
        wait_done(20, seen, cnt);
        checks++;
        if (!seen || cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL underflow_burst got done=%b count=%0d want 1 1", seen, cnt);
        end
    endtask

    task automatic test_start_ignored();
        int p0;
        bit seen;
        logic [LEN_W-1:0] cnt;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(W'(16'hF1 + i), i == 3);
        p0 = rd_pulses;
        fire_start(4'd4);
        tick();
        tick();
        start     = 1'b1;
        burst_len = 4'd2;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_pulses - p0 != 2) begin
            errors++;
            $display("[TB] FAIL restart_ignored got busy=%b reads=%0d want busy=1 reads=2",
                     busy, rd_pulses - p0);
        end
        m_ready = 1'b1;
        wait_done(30, seen, cnt);
        checks++;
        if (!seen || cnt !== 4'd4 || rd_pulses - p0 != 4 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL restart_complete got done=%b count=%0d reads=%0d left=%0d want 1 4 4 0",
                     seen, cnt, rd_pulses - p0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_fifo_starved();
        test_zero_len();
        test_reset_mid_burst();
        test_underflow();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
